// File: rtl/alpha_perm_unit.sv
// Row-rotating (alpha) permutation stage with a one-entry valid/ready output
// register, row-parity concurrent error detection and an output transfer counter.
module alpha_perm_unit #(
  parameter int unsigned BW       = 8,
  parameter int unsigned NR       = 4,
  parameter int unsigned NC       = 4,
  parameter int unsigned ROW_SKEW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NR*NC*BW-1:0]     in_data,
  input  logic [NR-1:0]           in_par,
  input  logic                    in_dir,
  input  logic [$clog2(NC)-1:0]   in_shamt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NR*NC*BW-1:0]     out_data,
  output logic [NR-1:0]           out_par,
  output logic                    ced_err,
  input  logic                    ced_clr,
  output logic [15:0]             xfer_cnt
);

  localparam int unsigned SW = $clog2(NC);
  localparam int unsigned RW = NC * BW;
  localparam int unsigned DW = NR * RW;

  // Column rotation of every row; dir=1 moves bytes toward higher columns.
  function automatic logic [DW-1:0] permute(input logic [DW-1:0] d,
                                            input logic          dir,
                                            input logic [SW-1:0] shamt);
    logic [SW-1:0] k;
    logic [SW-1:0] src;
    permute = '0;
    for (int unsigned r = 0; r < NR; r++) begin
      k = shamt + ((ROW_SKEW != 0) ? SW'(r) : SW'(0));
      for (int unsigned c = 0; c < NC; c++) begin
        src = dir ? (SW'(c) - k) : (SW'(c) + k);
        permute[(r*NC + c)*BW +: BW] = d[(r*NC + 32'(src))*BW +: BW];
      end
    end
  endfunction

  logic          in_xfer_c;
  logic          out_xfer_c;
  logic [DW-1:0] perm_c;
  logic [NR-1:0] row_par_c;
  logic          par_err_c;

  assign in_ready   = !out_valid || out_ready;
  assign in_xfer_c  = in_valid && in_ready;
  assign out_xfer_c = out_valid && out_ready;
  assign perm_c     = permute(in_data, in_dir, in_shamt);

  // Recompute row parity of the held state and compare with the carried parity.
  always_comb begin
    row_par_c = '0;
    for (int unsigned r = 0; r < NR; r++) begin
      row_par_c[r] = ^out_data[r*RW +: RW];
    end
    par_err_c = out_valid && (row_par_c != out_par);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_par   <= '0;
    end else if (in_xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= perm_c;
      out_par   <= in_par;
    end else if (out_xfer_c) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flag; a fresh mismatch beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ced_err <= 1'b0;
    end else if (par_err_c) begin
      ced_err <= 1'b1;
    end else if (ced_clr) begin
      ced_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= 16'd0;
    end else if (out_xfer_c) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule
